// File: rtl/key_expansion_engine.sv
// AES-128/192/256 key schedule: one word per cycle into storage, registered round-key read port.
// Optional build macro KEY_EXP_ZEROIZE_EN adds a ZERO state that wipes storage word by word.
module key_expansion_engine #(
  parameter int MAX_KEY_BITS = 256
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [255:0] key_in,
  output logic         ready,
  output logic         done,
  output logic         keys_valid,
  output logic         err,
  input  logic         rd_en,
  input  logic [3:0]   rd_round,
  output logic [127:0] rd_key,
  input  logic         zeroize
);

  localparam int DEPTH = (MAX_KEY_BITS <= 128) ? 44 :
                         (MAX_KEY_BITS <= 192) ? 52 : 60;

  localparam logic [255:0][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Byte 0x00 sits in the top lane, so the lane index is the inverted byte
  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[~w[31:24]], SBOX[~w[23:16]],
            SBOX[~w[15:8]],  SBOX[~w[7:0]]};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXPAND
`ifdef KEY_EXP_ZEROIZE_EN
    , S_ZERO
`endif
  } state_e;

  state_e        state_q, state_d;
  logic [5:0]    idx_q, idx_d;
  logic [2:0]    kcnt_q, kcnt_d;
  logic [7:0]    rcon_q, rcon_d;
  logic [1:0]    mode_q, mode_d;
  logic [31:0]   win_q [8];
  logic [31:0]   win_d [8];
  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic [127:0]  rd_key_q, rd_key_d;
`ifdef KEY_EXP_ZEROIZE_EN
  logic          zpend_q, zpend_d;
`else
  logic          unused_zeroize;
  assign unused_zeroize = zeroize;
`endif

  logic [31:0]   kw [8];
  logic [31:0]   ld128 [8];
  logic [31:0]   ld192 [8];
  logic [31:0]   ld256 [8];
  logic [31:0]   mem_w [DEPTH];
  logic [7:0]    ld_mask;
  logic          legal;
  logic          load;
  logic          wr_en;
  logic [5:0]    wr_addr;
  logic [31:0]   wr_data;

  logic [2:0]    nk_last;
  logic [5:0]    tot_last;
  logic [3:0]    nr;
  logic [31:0]   w_prev;
  logic [31:0]   w_old;
  logic [31:0]   sw_in;
  logic [31:0]   temp;
  logic [31:0]   new_word;
  logic          rd_ok;
  logic [127:0]  rd_word;

  // win[k] holds w[idx-1-k]; load images place the last key word in win[0]
  for (genvar k = 0; k < 8; k++) begin : g_key
    assign kw[k]    = key_in[255-32*k -: 32];
    assign ld256[k] = key_in[32*k+31 -: 32];
    if (k < 6) begin : g_192
      assign ld192[k] = key_in[32*k+95 -: 32];
    end else begin : g_192z
      assign ld192[k] = '0;
    end
    if (k < 4) begin : g_128
      assign ld128[k] = key_in[32*k+159 -: 32];
    end else begin : g_128z
      assign ld128[k] = '0;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_mem
    logic [31:0] word_q, word_d;
    if (i < 8) begin : g_ld
      always_comb begin
        word_d = word_q;
        if (load && ld_mask[i]) begin
          word_d = kw[i];
        end else if (wr_en && wr_addr == 6'(i)) begin
          word_d = wr_data;
        end
      end
    end else begin : g_wr
      always_comb begin
        word_d = word_q;
        if (wr_en && wr_addr == 6'(i)) begin
          word_d = wr_data;
        end
      end
    end
    always_ff @(posedge clk) begin
      word_q <= word_d;
    end
    assign mem_w[i] = word_q;
  end

  always_comb begin
    legal   = 1'b0;
    ld_mask = 8'hff;
    unique case (key_len)
      2'd0: begin
        legal   = 1'b1;
        ld_mask = 8'h0f;
      end
      2'd1: begin
        legal   = (MAX_KEY_BITS >= 192);
        ld_mask = 8'h3f;
      end
      2'd2: legal = (MAX_KEY_BITS >= 256);
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    nk_last  = 3'd7;
    tot_last = 6'd59;
    nr       = 4'd14;
    w_old    = win_q[7];
    unique case (1'b1)
      mode_q == 2'd0: begin
        nk_last  = 3'd3;
        tot_last = 6'd43;
        nr       = 4'd10;
        w_old    = win_q[3];
      end
      mode_q == 2'd1: begin
        nk_last  = 3'd5;
        tot_last = 6'd51;
        nr       = 4'd12;
        w_old    = win_q[5];
      end
      default: ;
    endcase
  end

  always_comb begin
    w_prev = win_q[0];
    sw_in  = (kcnt_q == 3'd0) ? rot_word(w_prev) : w_prev;
    temp   = w_prev;
    if (kcnt_q == 3'd0) begin
      temp = sub_word(sw_in) ^ {rcon_q, 24'h0};
    end else if (mode_q == 2'd2 && kcnt_q == 3'd4) begin
      temp = sub_word(sw_in);
    end
    new_word = w_old ^ temp;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    kcnt_d  = kcnt_q;
    rcon_d  = rcon_q;
    mode_d  = mode_q;
    win_d   = win_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    load    = 1'b0;
    wr_en   = 1'b0;
    wr_addr = idx_q;
    wr_data = new_word;
`ifdef KEY_EXP_ZEROIZE_EN
    zpend_d = zpend_q;
`endif
    unique case (state_q)
      S_IDLE: begin
`ifdef KEY_EXP_ZEROIZE_EN
        if (zpend_q || zeroize) begin
          state_d = S_ZERO;
          idx_d   = 6'd0;
          valid_d = 1'b0;
          zpend_d = 1'b0;
        end else
`endif
        if (start && legal) begin
          load    = 1'b1;
          mode_d  = key_len;
          idx_d   = 6'd4 + {3'd0, key_len, 1'b0};
          kcnt_d  = 3'd0;
          rcon_d  = 8'h01;
          valid_d = 1'b0;
          state_d = S_EXPAND;
          unique case (key_len)
            2'd0:    win_d = ld128;
            2'd1:    win_d = ld192;
            default: win_d = ld256;
          endcase
        end else if (start) begin
          err_d = 1'b1;
        end
      end
      S_EXPAND: begin
`ifdef KEY_EXP_ZEROIZE_EN
        if (zeroize) begin
          state_d = S_ZERO;
          idx_d   = 6'd0;
          valid_d = 1'b0;
        end else
`endif
        begin
          wr_en  = 1'b1;
          win_d  = '{new_word, win_q[0], win_q[1], win_q[2],
                     win_q[3], win_q[4], win_q[5], win_q[6]};
          kcnt_d = (kcnt_q == nk_last) ? 3'd0 : kcnt_q + 3'd1;
          if (kcnt_q == 3'd0) begin
            rcon_d = xtime(rcon_q);
          end
          if (idx_q == tot_last) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            valid_d = 1'b1;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
`ifdef KEY_EXP_ZEROIZE_EN
      S_ZERO: begin
        wr_en   = 1'b1;
        wr_data = '0;
        if (idx_q == 6'(DEPTH - 1)) begin
          state_d = S_IDLE;
          idx_d   = 6'd0;
          win_d   = '{default: '0};
        end else begin
          idx_d = idx_q + 6'd1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
    if (reset) begin
      load  = 1'b0;
      wr_en = 1'b0;
    end
  end

  always_comb begin
    rd_ok    = valid_q && (rd_round <= nr);
    rd_word  = {mem_w[{rd_round, 2'b00}], mem_w[{rd_round, 2'b01}],
                mem_w[{rd_round, 2'b10}], mem_w[{rd_round, 2'b11}]};
    rd_key_d = rd_key_q;
    if (rd_en) begin
      rd_key_d = rd_ok ? rd_word : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      kcnt_q   <= '0;
      rcon_q   <= 8'h01;
      mode_q   <= '0;
      win_q    <= '{default: '0};
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      rd_key_q <= '0;
`ifdef KEY_EXP_ZEROIZE_EN
      zpend_q  <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      kcnt_q   <= kcnt_d;
      rcon_q   <= rcon_d;
      mode_q   <= mode_d;
      win_q    <= win_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      rd_key_q <= rd_key_d;
`ifdef KEY_EXP_ZEROIZE_EN
      zpend_q  <= zpend_d;
`endif
    end
  end

  assign ready      = ready_q;
  assign done       = done_q;
  assign keys_valid = valid_q;
  assign err        = err_q;
  assign rd_key     = rd_key_q;

endmodule

// File: tb/tb_key_expansion_engine.sv
// Bench for key_expansion_engine: known-answer table, random keys against a
// GF(2^8) reference schedule, and hand sequences for err, abort and read gating.
module tb_key_expansion_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, start, rd_en, zeroize;
  logic [1:0]   key_len;
  logic [255:0] key_in;
  logic [3:0]   rd_round;
  logic         ready, done, keys_valid, err;
  logic [127:0] rd_key;

  logic         start_s, zeroize_s;
  logic [1:0]   key_len_s;
  logic         ready_s, done_s, keys_valid_s, err_s;
  logic [127:0] rd_key_s;

  key_expansion_engine dut (
    .clk(clk), .reset(reset), .start(start), .key_len(key_len),
    .key_in(key_in), .ready(ready), .done(done), .keys_valid(keys_valid),
    .err(err), .rd_en(rd_en), .rd_round(rd_round), .rd_key(rd_key),
    .zeroize(zeroize)
  );

  key_expansion_engine #(.MAX_KEY_BITS(128)) dut128 (
    .clk(clk), .reset(reset), .start(start_s), .key_len(key_len_s),
    .key_in(key_in), .ready(ready_s), .done(done_s),
    .keys_valid(keys_valid_s), .err(err_s), .rd_en(rd_en),
    .rd_round(rd_round), .rd_key(rd_key_s), .zeroize(zeroize_s)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] sb [256];

  localparam logic [255:0] K128 =
    {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 =
    {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  typedef struct {
    logic [1:0]   len;
    logic [255:0] key;
    int           round;
    logic [127:0] exp_key;
    int           exp_lat;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, expv);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse then affine map
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                  ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction

  function automatic logic [127:0] model_rk(input logic [1:0] len,
                                            input logic [255:0] key,
                                            input int r);
    logic [31:0]  w [60];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [255:0] k;
    int nk, nr, total;
    nk = 4 + 2 * int'(len);
    nr = nk + 6;
    total = 4 * (nr + 1);
    if (r > nr) return '0;
    k = key;
    for (int i = 0; i < nk; i++) begin
      w[i] = k[255:224];
      k = k << 32;
    end
    rc = 8'h01;
    for (int i = nk; i < total; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk == 8 && i % 8 == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  task automatic wait_ready();
    for (int k = 0; k < 200 && !(ready && ready_s); k++) @(negedge clk);
    chk("ready_wait", {126'd0, ready, ready_s}, 128'd3);
  endtask

  task automatic run_expand(input logic [1:0] len, input logic [255:0] key,
                            output int lat);
    start = 1'b1;
    key_len = len;
    key_in = key;
    @(negedge clk);
    start = 1'b0;
    chk("ready_drop", ready, 1'b0);
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic rd(input int r, output logic [127:0] d);
    rd_en = 1'b1;
    rd_round = 4'(r);
    @(negedge clk);
    d = rd_key;
    rd_en = 1'b0;
  endtask

  initial begin
    int lat, nk, nr;
    logic [127:0] d;
    logic [255:0] rk;
    logic [1:0] len;

    build_sbox();
    reset = 1'b1; start = 1'b0; rd_en = 1'b0; zeroize = 1'b0;
    key_len = 2'd0; key_in = '0; rd_round = 4'd0;
    start_s = 1'b0; zeroize_s = 1'b0; key_len_s = 2'd0;
    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_valid", keys_valid, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_rdkey", rd_key, '0);
    reset = 1'b0;
    wait_ready();
    rd(3, d);
    chk("rd_before_valid", d, '0);

    vecs[0] = '{2'd0, K128, 1, 128'ha0fafe1788542cb123a339392a6c7605, 40};
    vecs[1] = '{2'd0, K128, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 40};
    vecs[2] = '{2'd1, K192, 12, 128'he98ba06f448c773c8ecc720401002202, 46};
    vecs[3] = '{2'd1, K192, 13, 128'h0, 46};
    vecs[4] = '{2'd2, K256, 14, 128'hfe4890d1e6188d0b046df344706c631e, 52};
    for (int v = 0; v < 5; v++) begin
      run_expand(vecs[v].len, vecs[v].key, lat);
      chk($sformatf("kat%0d_lat", v), 128'(lat), 128'(vecs[v].exp_lat));
      chk($sformatf("kat%0d_valid", v), keys_valid, 1'b1);
      chk($sformatf("kat%0d_ready", v), ready, 1'b1);
      rd(vecs[v].round, d);
      chk($sformatf("kat%0d_key", v), d, vecs[v].exp_key);
    end

    // illegal mode leaves the AES-128 schedule intact
    run_expand(2'd0, K128, lat);
    start = 1'b1; key_len = 2'd3; key_in = K256;
    @(negedge clk);
    start = 1'b0;
    chk("err_pulse", err, 1'b1);
    chk("err_ready", ready, 1'b1);
    @(negedge clk);
    chk("err_clear", err, 1'b0);
    chk("err_valid", keys_valid, 1'b1);
    rd(10, d);
    chk("err_keep_r10", d, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    rd_round = 4'd1;
    @(negedge clk);
    chk("rd_hold", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // start during expansion is ignored, reads are gated off
    rk = {$urandom, $urandom, $urandom, $urandom,
          $urandom, $urandom, 64'h0};
    start = 1'b1; key_len = 2'd1; key_in = rk;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      if (k == 5) begin
        start = 1'b1; key_len = 2'd0; key_in = ~rk;
        rd_en = 1'b1; rd_round = 4'd0;
      end
      @(negedge clk);
      if (k == 5) begin
        start = 1'b0; rd_en = 1'b0;
        chk("busy_no_err", err, 1'b0);
        chk("busy_rd_zero", rd_key, '0);
        chk("busy_ready", ready, 1'b0);
      end
      if (done) begin
        lat = k;
        break;
      end
    end
    chk("busy_lat", 128'(lat), 128'd46);
    for (int r = 0; r <= 12; r += 4) begin
      rd(r, d);
      chk($sformatf("busy_r%0d", r), d, model_rk(2'd1, rk, r));
    end

    // reset in the middle of an expansion
    start = 1'b1; key_len = 2'd2; key_in = K256;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_ready", ready, 1'b1);
    chk("abort_done", done, 1'b0);
    chk("abort_valid", keys_valid, 1'b0);
    chk("abort_err", err, 1'b0);
    chk("abort_rdkey", rd_key, '0);
    reset = 1'b0;
    wait_ready();
    run_expand(2'd0, K128, lat);
    chk("abort_lat", 128'(lat), 128'd40);
    rd(10, d);
    chk("abort_r10", d, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    for (int n = 0; n < 6; n++) begin
      len = 2'($urandom_range(0, 2));
      rk = {$urandom, $urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom, $urandom};
      nk = 4 + 2 * int'(len);
      nr = nk + 6;
      run_expand(len, rk, lat);
      chk($sformatf("rnd%0d_lat", n), 128'(lat), 128'(4 * (nr + 1) - nk));
      for (int r = 0; r < 16; r++) begin
        rd(r, d);
        chk($sformatf("rnd%0d_m%0d_r%0d", n, len, r), d, model_rk(len, rk, r));
      end
    end

    // 128-bit-only instance rejects larger modes
    key_len_s = 2'd2; start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    chk("max128_err256", err_s, 1'b1);
    chk("max128_ready", ready_s, 1'b1);
    key_len_s = 2'd1; start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    chk("max128_err192", err_s, 1'b1);
    key_len_s = 2'd0; key_in = K128; start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (done_s) begin
        lat = k;
        break;
      end
    end
    chk("max128_lat", 128'(lat), 128'd40);
    rd_en = 1'b1; rd_round = 4'd10;
    @(negedge clk);
    rd_en = 1'b0;
    chk("max128_r10", rd_key_s, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

`ifdef KEY_EXP_ZEROIZE_EN
    begin
      int cnt;
      logic [31:0] acc;
      run_expand(2'd2, K256, lat);
      zeroize = 1'b1;
      @(negedge clk);
      zeroize = 1'b0;
      chk("zero_valid", keys_valid, 1'b0);
      cnt = ready ? 0 : 1;
      for (int k = 0; k < 100 && !ready; k++) begin
        @(negedge clk);
        if (!ready) cnt++;
      end
      chk("zero_len", 128'(cnt), 128'd60);
      acc = '0;
      for (int i = 0; i < 60; i++) acc = acc | dut.mem_w[i];
      chk("zero_mem", 128'(acc), '0);
      rd(14, d);
      chk("zero_rd", d, '0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
